// File: rtl/fifo_access_sched.sv
// Access scheduler owning both request ports of one FIFO.
// Round-robin burst arbitration of producers, interleaved with consumer reads.
module fifo_access_sched #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       rd_en,
  output logic                       rd_ack,
  output logic                       fifo_wr_req,
  output logic [WIDTH-1:0]           fifo_w_data,
  output logic                       fifo_rd_req,
  input  logic                       fifo_full_i,
  input  logic                       fifo_empty_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       burst_active
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        fsm;
  logic [IW-1:0] owner;
  logic [IW-1:0] last;
  logic [CW-1:0] burst_cnt;
  logic          turn;

  logic [IW-1:0] base;
  logic [IW-1:0] cand;
  logic          cand_ok;
  logic          owner_hold;
  logic          read_ok;
  logic          write_ok;
  logic          do_rd;
  logic          do_wr;
  logic          go_wr;

  assign owner_hold = (fsm == BURST) & req_valid[owner];

  // A dropped burst owner rescans from owner+1, same as last+1 after it ends.
  always_comb begin
    int idx;
    idx     = 0;
    cand    = '0;
    cand_ok = 1'b0;
    base    = (fsm == BURST) ? owner : last;
    if (owner_hold) begin
      cand    = owner;
      cand_ok = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(base) + k) % NUM_REQ;
        if (!cand_ok && req_valid[idx]) begin
          cand    = IW'(idx);
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign read_ok  = rd_en & ~fifo_empty_i;
  assign write_ok = cand_ok & ~fifo_full_i;
  assign do_rd    = read_ok & (~write_ok | turn);
  assign do_wr    = write_ok & ~do_rd;
  assign go_wr    = rstn & do_wr;

  assign rd_ack       = rstn & do_rd;
  assign fifo_rd_req  = rstn & do_rd;
  assign fifo_wr_req  = go_wr;
  assign req_ready    = go_wr ? (NUM_REQ'(1) << cand) : '0;
  assign grant_id     = go_wr ? cand : '0;
  assign fifo_w_data  = go_wr ? req_data[int'(cand)*WIDTH +: WIDTH] : '0;
  assign burst_active = rstn & (fsm == BURST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm       <= IDLE;
      owner     <= '0;
      last      <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
      turn      <= 1'b1;
    end else begin
      if (read_ok & write_ok)
        turn <= ~turn;
      unique case (fsm)
        IDLE: begin
          if (do_wr) begin
            if (MAX_BURST == 1) begin
              last <= cand;
            end else begin
              owner     <= cand;
              burst_cnt <= CW'(1);
              fsm       <= BURST;
            end
          end
        end
        BURST: begin
          if (req_valid[owner]) begin
            if (do_wr) begin
              if (burst_cnt == CW'(MAX_BURST - 1)) begin
                fsm       <= IDLE;
                last      <= owner;
                burst_cnt <= '0;
              end else begin
                burst_cnt <= burst_cnt + CW'(1);
              end
            end
          end else begin
            last <= owner;
            if (do_wr) begin
              owner     <= cand;
              burst_cnt <= CW'(1);
            end else begin
              fsm       <= IDLE;
              burst_cnt <= '0;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
